// File: rtl/array_stream_pkg.sv
// Shared types and helpers for the array element streamer datapath.
// Holds the streamer state encoding and the index-width rule.
package array_stream_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

    // An array of one element still needs a one-bit index port.
    function automatic int elem_index_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/array_elem_streamer_elem_fn.sv
// Per-element function f(x, i), shared by the serial streamer and the
// parallel generate-loop writer so both always agree on the result.
module elem_fn #(
    parameter int W         = 32,
    parameter int IW        = 4,
    parameter int ADD_INDEX = 0
) (
    input  logic [W-1:0]  x,
    input  logic [IW-1:0] i,
    output logic [W-1:0]  y
);

    logic [W-1:0] i_ext_s;

    // Index is zero-extended; the carry out of the add is dropped.
    assign i_ext_s = W'(i);
    assign y       = (ADD_INDEX != 0) ? (x + i_ext_s) : x;

endmodule

// File: rtl/array_elem_streamer.sv
// Accepts a whole packed array in one handshake and streams its elements
// out in index order, one per cycle, through elem_fn.
module array_elem_streamer
    import array_stream_pkg::*;
#(
    parameter int N         = 10,
    parameter int W         = 32,
    parameter int IW        = elem_index_width(N),
    parameter int ADD_INDEX = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [N*W-1:0] load_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_index,
    output logic           out_last,
    output logic           busy
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    generate
        if (N < 1) begin : g_bad_n
            $error("array_elem_streamer: N must be at least 1");
        end
    endgenerate

    stream_state_e  state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N*W-1:0] arr_q, arr_d;
    logic [W-1:0]   elem_s;
    logic [W-1:0]   fn_s;
    logic           streaming_s;

    // Next-state: the index is cleared on the last beat so IDLE always shows index 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        arr_d   = arr_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    arr_d   = load_data;
                    idx_d   = {IW{1'b0}};
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = {IW{1'b0}};
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                idx_d   = {IW{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= {IW{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Array register needs no reset: out_data is gated to zero outside STREAM.
    always_ff @(posedge clk) begin
        arr_q <= arr_d;
    end

    // Select the element addressed by the current index.
    always_comb begin
        elem_s = arr_q[int'(idx_q) * W +: W];
    end

    elem_fn #(
        .W         (W),
        .IW        (IW),
        .ADD_INDEX (ADD_INDEX)
    ) u_elem_fn (
        .x (elem_s),
        .i (idx_q),
        .y (fn_s)
    );

    assign streaming_s = (state_q == STREAM);
    assign load_ready  = ~streaming_s;
    assign out_valid   = streaming_s;
    assign busy        = streaming_s;
    assign out_data    = streaming_s ? fn_s : {W{1'b0}};
    assign out_index   = idx_q;
    assign out_last    = (idx_q == LAST_IDX);

endmodule

// File: tb/tb_array_elem_streamer.sv
// Scoreboard bench: three streamer instances (identity N=10, add-index N=10,
// identity N=1) checked every cycle against a queue-based reference model.
module tb_array_elem_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        lv[3], lr[3], ov[3], orr[3], ol[3], bz[3];
    logic [319:0] ld[2];
    logic [31:0] ld_c;
    logic [31:0] od[3];
    logic [3:0]  oi_a, oi_b;
    logic [0:0]  oi_c;

    typedef struct {
        logic [31:0] d;
        int          idx;
        bit          last;
    } exp_t;

    exp_t sb[3][$];
    int   nn[3]   = '{10, 10, 1};
    int   addi[3] = '{0, 1, 0};
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   started = 1'b0;

    array_elem_streamer #(.N(10), .W(32), .ADD_INDEX(0)) dut_a (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]),
        .load_data(ld[0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .out_data(od[0]), .out_index(oi_a), .out_last(ol[0]), .busy(bz[0]));

    array_elem_streamer #(.N(10), .W(32), .ADD_INDEX(1)) dut_b (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]),
        .load_data(ld[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .out_data(od[1]), .out_index(oi_b), .out_last(ol[1]), .busy(bz[1]));

    array_elem_streamer #(.N(1), .W(32), .ADD_INDEX(0)) dut_c (
        .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(lr[2]),
        .load_data(ld_c), .out_valid(ov[2]), .out_ready(orr[2]),
        .out_data(od[2]), .out_index(oi_c), .out_last(ol[2]), .busy(bz[2]));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    // Reference: a frame is a queue of N beats; valid whenever beats remain.
    task automatic step(input int k, input int oidx);
        bit          ev;
        exp_t        e;
        logic [31:0] x;
        ev = (sb[k].size() != 0);
        chk("out_valid", k, {31'd0, ov[k]}, {31'd0, ev});
        chk("busy", k, {31'd0, bz[k]}, {31'd0, ev});
        chk("load_ready", k, {31'd0, lr[k]}, {31'd0, !ev});
        if (ev) begin
            chk("out_data", k, od[k], sb[k][0].d);
            chk("out_index", k, 32'(oidx), 32'(sb[k][0].idx));
            chk("out_last", k, {31'd0, ol[k]}, {31'd0, sb[k][0].last});
        end else begin
            chk("idle_data", k, od[k], 32'd0);
            chk("idle_index", k, 32'(oidx), 32'd0);
            chk("idle_last", k, {31'd0, ol[k]}, {31'd0, (nn[k] == 1)});
        end
        if (ov[k] && orr[k] && ev) void'(sb[k].pop_front());
        if (lv[k] && lr[k] && !rst) begin
            for (int i = 0; i < nn[k]; i++) begin
                if (k == 2) x = ld_c;
                else        x = ld[k][i*32 +: 32];
                e.d    = (addi[k] != 0) ? (x + 32'(i)) : x;
                e.idx  = i;
                e.last = (i == nn[k] - 1);
                sb[k].push_back(e);
            end
        end
        if (rst) sb[k].delete();
    endtask

    always @(negedge clk) begin
        if (started) begin
            step(0, int'(oi_a));
            step(1, int'(oi_b));
            step(2, int'(oi_c));
        end
    end

    function automatic logic [319:0] mk(input int base);
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = 32'(base + i);
        return r;
    endfunction

    task automatic load(input int k, input logic [319:0] d, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        lv[k] = 1'b1;
        if (k == 2) ld_c = d[31:0];
        else        ld[k] = d;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (lr[k]) begin
                got = 1'b1;
                acc = cyc;
            end
        end
        @(posedge clk);
        #1;
        lv[k] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL load_accept dut%0d: got no acceptance expected one within 400 cycles", k);
        end
    endtask

    task automatic drain(input int k, input bit rnd);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk);
            #1;
            orr[k] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!ov[k] && sb[k].size() == 0) done = 1'b1;
        end
        orr[k] = 1'b1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain dut%0d: got frame still pending (%0d beats) expected done", k, sb[k].size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        logic [319:0] r;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lv[k]  = 1'b0;
            orr[k] = 1'b1;
        end
        ld[0] = '0;
        ld[1] = '0;
        ld_c  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        started = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame 100..109 at full rate.
        load(0, mk(100), a1);
        drain(0, 1'b0);

        // Backpressure on element cycles 2-4 and 7.
        load(0, mk(100), a1);
        for (int c = 2; c <= 9; c++) begin
            @(posedge clk);
            #1;
            orr[0] = !(c inside {2, 3, 4, 7});
        end
        drain(0, 1'b0);

        // Add-index with wrap modulo 2^32.
        load(1, {320{1'b1}}, a1);
        drain(1, 1'b0);

        // Back-to-back: second load accepted in the single IDLE cycle.
        load(0, mk(200), a1);
        load(0, mk(300), a2);
        chk("b2b_gap", 0, 32'(a2 - a1), 32'd11);
        drain(0, 1'b0);

        // Reset after element 3 is accepted.
        load(0, mk(500), a1);
        repeat (4) @(posedge clk);
        #1;
        rst    = 1'b1;
        orr[0] = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        orr[0] = 1'b1;
        chk("rst_out_valid", 0, {31'd0, ov[0]}, 32'd0);
        chk("rst_busy", 0, {31'd0, bz[0]}, 32'd0);
        chk("rst_load_ready", 0, {31'd0, lr[0]}, 32'd1);
        load(0, mk(7), a1);
        drain(0, 1'b0);

        // Single-element array.
        load(2, mk(42), a1);
        drain(2, 1'b0);

        // Random frames with random backpressure on every instance.
        for (int k = 0; k < 3; k++) begin
            for (int f = 0; f < 3; f++) begin
                for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
                load(k, r, a1);
                for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
                load(k, r, a2);
                drain(k, 1'b1);
            end
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
